// File: rtl/time_entry_pkg.sv
// Shared types and constants for the keypad time-entry path.
// Covers sequencer states, key codes, digit positions and digit range limits.
package time_entry_pkg;

  typedef enum logic [2:0] {
    IDLE,
    W_LH,
    W_RH,
    W_LM,
    W_RM,
    DONE
  } state_e;

  localparam logic [3:0] KEY_CANCEL = 4'hA;
  localparam logic [3:0] DIGIT_MAX  = 4'd9;

  localparam logic [1:0] IDX_LH = 2'd0;
  localparam logic [1:0] IDX_RH = 2'd1;
  localparam logic [1:0] IDX_LM = 2'd2;
  localparam logic [1:0] IDX_RM = 2'd3;

  localparam logic [3:0] LH_MAX24     = 4'd2;
  localparam logic [3:0] LH_MAX12     = 4'd1;
  localparam logic [3:0] MIN_TENS_MAX = 4'd5;
  localparam logic [3:0] RH_MAX_LH2   = 4'd3;
  localparam logic [3:0] RH_MAX_LH1   = 4'd2;

  function automatic logic [1:0] stateIndex(input state_e s);
    case (s)
      W_RH:    return IDX_RH;
      W_LM:    return IDX_LM;
      W_RM:    return IDX_RM;
      default: return IDX_LH;
    endcase
  endfunction

endpackage

// File: rtl/digit_range_check.sv
// Combinational legality check for one keyed digit at a given position.
// The RH limit depends on the hour-tens digit accepted earlier in the session.
module digit_range_check
  import time_entry_pkg::*;
#(
  parameter bit HOUR_24 = 1'b1
) (
  input  logic [1:0] digitIndex,
  input  logic [3:0] d,
  input  logic [3:0] storedLh,
  output logic       ok
);

  always_comb begin
    ok = 1'b0;
    case (digitIndex)
      IDX_LH: ok = HOUR_24 ? (d <= LH_MAX24) : (d <= LH_MAX12);
      IDX_RH: begin
        if (HOUR_24)
          ok = (storedLh == LH_MAX24) ? (d <= RH_MAX_LH2) : (d <= DIGIT_MAX);
        else
          // 12-hour clock has no hour 00, so LH=0 needs a non-zero units digit
          ok = (storedLh == LH_MAX12) ? (d <= RH_MAX_LH1)
                                      : ((d != 4'd0) && (d <= DIGIT_MAX));
      end
      IDX_LM:  ok = (d <= MIN_TENS_MAX);
      default: ok = (d <= DIGIT_MAX);
    endcase
  end

endmodule

// File: rtl/keypad_time_entry_sequencer.sv
// Sequences keypad digits into ordered LH/RH/LM/RM write strobes for the
// time or alarm registers, with cancel key and inactivity timeout.
module keypad_time_entry_sequencer
  import time_entry_pkg::*;
#(
  parameter bit          HOUR_24        = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 50000000,
  parameter int unsigned TO_W           = 26
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       startTime,
  input  logic       startAlarm,
  input  logic       keyValid,
  input  logic [3:0] keyCode,
  output logic       setLH,
  output logic       setRH,
  output logic       setLM,
  output logic       setRM,
  output logic [3:0] numPad,
  output logic       setSignal,
  output logic       alarmSignal,
  output logic [1:0] digitIndex,
  output logic       rejectPulse,
  output logic       donePulse,
  output logic       abortPulse
);

  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  state_e          state, nxtState;
  logic [TO_W-1:0] toCnt, nxtCnt;
  logic [3:0]      storedLh, nxtStoredLh;
  logic [1:0]      curIdx;
  logic            inWait, isDigit, isCancel, rangeOk;
  logic            accept, reject, expire, abort;

  logic       nxtSetLH, nxtSetRH, nxtSetLM, nxtSetRM;
  logic [3:0] nxtNumPad;
  logic       nxtSetSignal, nxtAlarmSignal;
  logic [1:0] nxtDigitIndex;
  logic       nxtReject, nxtDone, nxtAbort;

  digit_range_check #(.HOUR_24(HOUR_24)) rangeCheck (
    .digitIndex(curIdx),
    .d         (keyCode),
    .storedLh  (storedLh),
    .ok        (rangeOk)
  );

  // Key events and timeout qualification for the current cycle
  always_comb begin
    curIdx   = stateIndex(state);
    inWait   = (state == W_LH) || (state == W_RH) || (state == W_LM) || (state == W_RM);
    isDigit  = keyValid && (keyCode <= DIGIT_MAX);
    isCancel = keyValid && (keyCode == KEY_CANCEL);
    accept   = inWait && isDigit && rangeOk;
    reject   = inWait && isDigit && !rangeOk;
    // Ignored codes (B-F) do not hold off expiry
    expire   = inWait && !isDigit && !isCancel && (toCnt == TO_LAST);
    abort    = inWait && (isCancel || expire);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      toCnt       <= '0;
      storedLh    <= '0;
      setLH       <= 1'b0;
      setRH       <= 1'b0;
      setLM       <= 1'b0;
      setRM       <= 1'b0;
      numPad      <= '0;
      setSignal   <= 1'b0;
      alarmSignal <= 1'b0;
      digitIndex  <= '0;
      rejectPulse <= 1'b0;
      donePulse   <= 1'b0;
      abortPulse  <= 1'b0;
    end else begin
      state       <= nxtState;
      toCnt       <= nxtCnt;
      storedLh    <= nxtStoredLh;
      setLH       <= nxtSetLH;
      setRH       <= nxtSetRH;
      setLM       <= nxtSetLM;
      setRM       <= nxtSetRM;
      numPad      <= nxtNumPad;
      setSignal   <= nxtSetSignal;
      alarmSignal <= nxtAlarmSignal;
      digitIndex  <= nxtDigitIndex;
      rejectPulse <= nxtReject;
      donePulse   <= nxtDone;
      abortPulse  <= nxtAbort;
    end
  end

  always_comb begin
    nxtState = state;
    case (state)
      IDLE: if (startTime || startAlarm) nxtState = W_LH;
      W_LH: if (abort) nxtState = IDLE; else if (accept) nxtState = W_RH;
      W_RH: if (abort) nxtState = IDLE; else if (accept) nxtState = W_LM;
      W_LM: if (abort) nxtState = IDLE; else if (accept) nxtState = W_RM;
      W_RM: if (abort) nxtState = IDLE; else if (accept) nxtState = DONE;
      default: nxtState = IDLE;
    endcase
  end

  always_comb begin
    nxtSetLH      = accept && (curIdx == IDX_LH);
    nxtSetRH      = accept && (curIdx == IDX_RH);
    nxtSetLM      = accept && (curIdx == IDX_LM);
    nxtSetRM      = accept && (curIdx == IDX_RM);
    nxtNumPad     = accept ? keyCode : numPad;
    nxtStoredLh   = (accept && (curIdx == IDX_LH)) ? keyCode : storedLh;
    nxtReject     = reject;
    nxtAbort      = abort;
    nxtDone       = (state == DONE);
    nxtDigitIndex = stateIndex(nxtState);
    nxtCnt        = (inWait && !accept && !reject && !abort) ? toCnt + 1'b1 : '0;

    // Mode lines lag the DONE state by one cycle so they stay high alongside donePulse
    nxtSetSignal   = setSignal;
    nxtAlarmSignal = alarmSignal;
    if (state == IDLE) begin
      nxtSetSignal   = startTime;
      nxtAlarmSignal = startAlarm && !startTime;
    end else if (abort) begin
      nxtSetSignal   = 1'b0;
      nxtAlarmSignal = 1'b0;
    end
  end

endmodule

// File: tb/tb_keypad_time_entry_sequencer.sv
// Directed bench: a 24-hour and a 12-hour sequencer (timeout 8 cycles) share
// one stimulus; each vector names which instance's outputs it checks.
module tb_keypad_time_entry_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       startTime = 1'b0;
  logic       startAlarm = 1'b0;
  logic       keyValid = 1'b0;
  logic [3:0] keyCode = 4'h0;

  logic       aLH, aRH, aLM, aRM, aSet, aAlm, aRej, aDone, aAbt;
  logic [3:0] aNum;
  logic [1:0] aIdx;
  logic       bLH, bRH, bLM, bRM, bSet, bAlm, bRej, bDone, bAbt;
  logic [3:0] bNum;
  logic [1:0] bIdx;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  keypad_time_entry_sequencer #(.HOUR_24(1'b1), .TIMEOUT_CYCLES(8), .TO_W(4)) dut24 (
    .clk(clk), .rst(rst), .startTime(startTime), .startAlarm(startAlarm),
    .keyValid(keyValid), .keyCode(keyCode),
    .setLH(aLH), .setRH(aRH), .setLM(aLM), .setRM(aRM), .numPad(aNum),
    .setSignal(aSet), .alarmSignal(aAlm), .digitIndex(aIdx),
    .rejectPulse(aRej), .donePulse(aDone), .abortPulse(aAbt)
  );

  keypad_time_entry_sequencer #(.HOUR_24(1'b0), .TIMEOUT_CYCLES(8), .TO_W(4)) dut12 (
    .clk(clk), .rst(rst), .startTime(startTime), .startAlarm(startAlarm),
    .keyValid(keyValid), .keyCode(keyCode),
    .setLH(bLH), .setRH(bRH), .setLM(bLM), .setRM(bRM), .numPad(bNum),
    .setSignal(bSet), .alarmSignal(bAlm), .digitIndex(bIdx),
    .rejectPulse(bRej), .donePulse(bDone), .abortPulse(bAbt)
  );

  // {LH,RH,LM,RM,numPad[4],set,alarm,idx[2],reject,done,abort}
  logic [14:0] obs24, obs12;
  assign obs24 = {aLH, aRH, aLM, aRM, aNum, aSet, aAlm, aIdx, aRej, aDone, aAbt};
  assign obs12 = {bLH, bRH, bLM, bRM, bNum, bSet, bAlm, bIdx, bRej, bDone, bAbt};

  typedef struct {
    logic        r, st, sa, kv;
    logic [3:0]  kc;
    bit          sel12;
    logic [14:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [14:0] ex(input bit lh, rh, lm, rm, input int num,
                                     input bit set, alm, input int idx,
                                     input bit rej, done, abt);
    return {lh, rh, lm, rm, 4'(num), set, alm, 2'(idx), rej, done, abt};
  endfunction

  task automatic add(input logic r, st, sa, kv, input logic [3:0] kc,
                     input bit sel12, input logic [14:0] e);
    vec_t v;
    v.r = r; v.st = st; v.sa = sa; v.kv = kv; v.kc = kc; v.sel12 = sel12; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic step(input logic r, st, sa, kv, input logic [3:0] kc);
    rst = r; startTime = st; startAlarm = sa; keyValid = kv; keyCode = kc;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string nm, input logic [14:0] got, input logic [14:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b (LH RH LM RM num set alm idx rej done abt)",
               nm, got, want);
    end
  endtask

  localparam logic [14:0] Z = '0;

  initial begin
    // 24h: time entry 2,3,5,9 with keys three cycles apart
    add(0,1,0,0,4'h0,0, ex(0,0,0,0,0,1,0,0,0,0,0));
    add(0,0,0,1,4'h2,0, ex(1,0,0,0,2,1,0,1,0,0,0));
    add(0,0,0,0,4'h0,0, ex(0,0,0,0,2,1,0,1,0,0,0));
    add(0,0,0,0,4'h0,0, ex(0,0,0,0,2,1,0,1,0,0,0));
    add(0,0,0,1,4'h3,0, ex(0,1,0,0,3,1,0,2,0,0,0));
    add(0,0,0,0,4'h0,0, ex(0,0,0,0,3,1,0,2,0,0,0));
    add(0,0,0,0,4'h0,0, ex(0,0,0,0,3,1,0,2,0,0,0));
    add(0,0,0,1,4'h5,0, ex(0,0,1,0,5,1,0,3,0,0,0));
    add(0,0,0,0,4'h0,0, ex(0,0,0,0,5,1,0,3,0,0,0));
    add(0,0,0,0,4'h0,0, ex(0,0,0,0,5,1,0,3,0,0,0));
    add(0,0,0,1,4'h9,0, ex(0,0,0,1,9,1,0,0,0,0,0));
    add(0,0,0,0,4'h0,0, ex(0,0,0,0,9,1,0,0,0,1,0));
    add(0,0,0,0,4'h0,0, ex(0,0,0,0,9,0,0,0,0,0,0));
    // 24h alarm: LH 3 rejected, 2 ok; RH 4 rejected, 0 ok; LM 6 rejected; F ignored; cancel
    add(0,0,1,0,4'h0,0, ex(0,0,0,0,9,0,1,0,0,0,0));
    add(0,0,0,1,4'h3,0, ex(0,0,0,0,9,0,1,0,1,0,0));
    add(0,0,0,1,4'h2,0, ex(1,0,0,0,2,0,1,1,0,0,0));
    add(0,0,0,1,4'h4,0, ex(0,0,0,0,2,0,1,1,1,0,0));
    add(0,0,0,1,4'h0,0, ex(0,1,0,0,0,0,1,2,0,0,0));
    add(0,0,0,1,4'h6,0, ex(0,0,0,0,0,0,1,2,1,0,0));
    add(0,0,0,1,4'hF,0, ex(0,0,0,0,0,0,1,2,0,0,0));
    add(0,0,0,1,4'hA,0, ex(0,0,0,0,0,0,0,0,0,0,1));
    // Both starts together, stray start mid-session, cancel, keys after cancel
    add(0,1,1,0,4'h0,0, ex(0,0,0,0,0,1,0,0,0,0,0));
    add(0,0,1,0,4'h0,0, ex(0,0,0,0,0,1,0,0,0,0,0));
    add(0,0,0,1,4'h1,0, ex(1,0,0,0,1,1,0,1,0,0,0));
    add(0,0,0,1,4'hA,0, ex(0,0,0,0,1,0,0,0,0,0,1));
    add(0,0,0,1,4'h5,0, ex(0,0,0,0,1,0,0,0,0,0,0));
    add(0,0,0,1,4'h3,0, ex(0,0,0,0,1,0,0,0,0,0,0));
    // 12h instance from a clean reset
    add(1,0,0,0,4'h0,1, Z);
    add(0,1,0,0,4'h0,1, ex(0,0,0,0,0,1,0,0,0,0,0));
    add(0,0,0,1,4'h0,1, ex(1,0,0,0,0,1,0,1,0,0,0));
    add(0,0,0,1,4'h0,1, ex(0,0,0,0,0,1,0,1,1,0,0));
    add(0,0,0,1,4'hA,1, ex(0,0,0,0,0,0,0,0,0,0,1));
    add(0,1,0,0,4'h0,1, ex(0,0,0,0,0,1,0,0,0,0,0));
    add(0,0,0,1,4'h2,1, ex(0,0,0,0,0,1,0,0,1,0,0));
    add(0,0,0,1,4'h1,1, ex(1,0,0,0,1,1,0,1,0,0,0));
    add(0,0,0,1,4'h3,1, ex(0,0,0,0,1,1,0,1,1,0,0));
    add(0,0,0,1,4'h2,1, ex(0,1,0,0,2,1,0,2,0,0,0));
    add(0,0,0,1,4'h0,1, ex(0,0,1,0,0,1,0,3,0,0,0));
    add(0,0,0,1,4'h0,1, ex(0,0,0,1,0,1,0,0,0,0,0));
    add(0,0,0,0,4'h0,1, ex(0,0,0,0,0,1,0,0,0,1,0));
    add(0,0,0,0,4'h0,1, ex(0,0,0,0,0,0,0,0,0,0,0));
    // Reset mid-session with a key present: no strobe, no abort
    add(0,1,0,0,4'h0,1, ex(0,0,0,0,0,1,0,0,0,0,0));
    add(0,0,0,1,4'h1,1, ex(1,0,0,0,1,1,0,1,0,0,0));
    add(0,0,0,1,4'h2,1, ex(0,1,0,0,2,1,0,2,0,0,0));
    add(1,0,0,1,4'h5,1, Z);

    step(1,0,0,0,4'h0);
    step(1,0,0,0,4'h0);
    check("reset24", obs24, Z);
    check("reset12", obs12, Z);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].r, vecs[i].st, vecs[i].sa, vecs[i].kv, vecs[i].kc);
      check($sformatf("vec[%0d]", i), vecs[i].sel12 ? obs12 : obs24, vecs[i].exp);
    end

    // Timeout: abort on the 8th idle cycle after entering W_LH
    step(0,1,0,0,4'h0);
    check("to_start", obs24, ex(0,0,0,0,0,1,0,0,0,0,0));
    for (int i = 0; i < 7; i++) begin
      step(0,0,0,0,4'h0);
      check($sformatf("to_wait[%0d]", i), obs24, ex(0,0,0,0,0,1,0,0,0,0,0));
    end
    step(0,0,0,0,4'h0);
    check("to_expire", obs24, ex(0,0,0,0,0,0,0,0,0,0,1));

    // A digit in the expiry cycle wins; an ignored code does not
    step(0,1,0,0,4'h0);
    check("to2_start", obs24, ex(0,0,0,0,0,1,0,0,0,0,0));
    for (int i = 0; i < 7; i++) step(0,0,0,0,4'h0);
    step(0,0,0,1,4'h2);
    check("to2_key_wins", obs24, ex(1,0,0,0,2,1,0,1,0,0,0));
    for (int i = 0; i < 7; i++) step(0,0,0,0,4'h0);
    check("to2_before", obs24, ex(0,0,0,0,2,1,0,1,0,0,0));
    step(0,0,0,1,4'hB);
    check("to2_ignored_expires", obs24, ex(0,0,0,0,2,0,0,0,0,0,1));
    step(0,0,0,0,4'h0);
    check("to2_idle", obs24, ex(0,0,0,0,2,0,0,0,0,0,0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/keypad_time_entry_sequencer.md
Name: keypad_time_entry_sequencer

Overview:
- Front end of the time/alarm digit-setting path.
- Turns one-cycle keypad events into an ordered, range-checked sequence of per-digit write strobes: hour tens, hour units, minute tens, minute units.
- Drives the digit-select strobes, the numPad value and the setSignal/alarmSignal mode lines consumed by the digit-register controller.
- Includes an inactivity timeout and a cancel key.

Parameters:
- HOUR_24, 1, 1 = 24-hour limits (00-23); 0 = 12-hour limits (01-12).
- TIMEOUT_CYCLES, 50000000, clk cycles without a key in a WAIT state before abort; must be ≥ 2.
- TO_W, 26, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous and active-high.
- startTime  in  1  one-cycle request to begin time entry.
- startAlarm  in  1  one-cycle request to begin alarm entry.
- keyValid  in  1  one-cycle pulse; keyCode is valid this cycle.
- keyCode  in  4  0-9 are digits; 4'hA is cancel; 4'hB-4'hF are ignored.
- setLH  out  1  one-cycle write strobe, hour-tens digit.
- setRH  out  1  one-cycle write strobe, hour-units digit.
- setLM  out  1  one-cycle write strobe, minute-tens digit.
- setRM  out  1  one-cycle write strobe, minute-units digit.
- numPad  out  4  digit value accompanying a strobe; holds its last value otherwise.
- setSignal  out  1  high while a time-entry session is active.
- alarmSignal  out  1  high while an alarm-entry session is active.
- digitIndex  out  2  next digit expected: 0=LH, 1=RH, 2=LM, 3=RM; used for cursor blink.
- rejectPulse  out  1  one cycle; a digit key was out of range.
- donePulse  out  1  one cycle; all four digits were accepted.
- abortPulse  out  1  one cycle; the session ended by cancel or timeout.

Behaviour:
- All outputs are registered.
- Reset values: every output is 0; state is IDLE; the timeout counter is 0; the stored LH copy is 0.
- States: IDLE, W_LH, W_RH, W_LM, W_RM, DONE.
- IDLE:
  - startTime → W_LH with setSignal=1.
  - startAlarm alone → W_LH with alarmSignal=1.
  - Both asserted in the same cycle: time entry wins.
  - Keys received in IDLE are ignored.
- Start requests outside IDLE are ignored.
- At most one of setSignal/alarmSignal is high at any time; each holds constant from session entry through DONE.
- In a W_x state, keyValid with a digit d:
  - d in range: next cycle numPad=d, the matching set strobe=1 for exactly one cycle, state advances, the timeout counter clears.
  - d out of range: next cycle rejectPulse=1, state unchanged, the timeout counter clears.
- Range rules with HOUR_24=1:
  - LH ≤ 2.
  - RH ≤ 9; RH ≤ 3 if the stored LH = 2.
  - LM ≤ 5.
  - RM ≤ 9.
- Range rules with HOUR_24=0:
  - LH ≤ 1.
  - RH ≤ 2 if LH = 1.
  - RH in 1..9 if LH = 0.
  - LM and RM as for 24-hour.
- The stored LH is captured when LH is accepted and is used only for the RH check.
- Cancel (4'hA) in any W_x state: next cycle abortPulse=1, state → IDLE, setSignal and alarmSignal fall in that same cycle.
  - Consequence: the downstream controller clears its digits. This is intended.
- Codes 4'hB-4'hF: no effect, and the timeout counter does not clear.
- Timeout:
  - The counter increments every cycle in W_x states without an accepted or rejected key.
  - When it reaches TIMEOUT_CYCLES-1: abortPulse, → IDLE, as for cancel.
  - A key arriving in the same cycle as expiry takes precedence over the timeout.
- After RM is accepted: DONE for exactly one cycle with donePulse=1 and the mode line still high, then IDLE with the mode line low.
- Latency: a key sampled in cycle N produces its strobe, reject or abort in cycle N+1. At most one strobe is high per cycle.
- digitIndex tracks the W_x state; it is 0 in IDLE and DONE.
- rst asserted mid-session: all outputs are 0 on the next edge, with no abortPulse and no strobe.

Decomposition:
- Shared package (time_entry_pkg):
  - state enum;
  - key code constants KEY_CANCEL=4'hA;
  - digit index constants;
  - range limit constants: LH_MAX24=2, LH_MAX12=1, MIN_TENS_MAX=5.
- One natural sub-module, digit_range_check: combinational; inputs digitIndex, d, stored LH, HOUR_24; output ok.
- The FSM, timeout counter and output registers stay in the top level.

Test Plan:
- startTime, then keys 2,3,5,9 spaced 3 cycles apart → setLH(2), setRH(3), setLM(5), setRM(9) each one cycle after its key; donePulse on the cycle after setRM; setSignal high throughout, low one cycle after donePulse.
- startAlarm, keys 2,4 (HOUR_24=1) → setLH(2), then rejectPulse for 4 with no setRH and digitIndex stays 1; key 0 → setRH(0).
- startTime and startAlarm in the same cycle → only setSignal=1; startAlarm mid-session is ignored.
- startTime, key 1, key 4'hA → setLH(1), then abortPulse with setSignal=0 on the same cycle; subsequent digits produce no strobes.
- TIMEOUT_CYCLES=8, startTime and no keys → abortPulse exactly 8 cycles after entering W_LH; a key in the expiry cycle is accepted instead.
- HOUR_24=0: keys 0,0 → reject on RH; keys 1,3 → reject on RH; 1,2,0,0 → done. rst asserted after the second digit → all outputs are 0 the next cycle and there is no abortPulse.
